// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide on magnitudes.
// Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.

`ifndef ALU_MUL
`define ALU_MUL    6'h20
`define ALU_MULH   6'h21
`define ALU_MULHSU 6'h22
`define ALU_MULHU  6'h23
`define ALU_DIV    6'h24
`define ALU_DIVU   6'h25
`define ALU_REM    6'h26
`define ALU_REMU   6'h27
`endif

// state | meaning
// IDLE  | waiting for an accepted M-extension start
// CALC  | one multiply/divide bit per cycle, 32 cycles
// DONE  | result valid, done pulsed for one cycle
module muldiv_unit (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [5:0]  alucode,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [5:0]  op_q;
   logic        neg_q;
   logic [31:0] mag_b_q;
   logic [31:0] acc_hi_q;
   logic [31:0] acc_lo_q;
   logic [4:0]  cnt_q;

   logic        in_m, in_div, in_rem, in_sgn1, in_sgn2, in_signed_div;
   logic        neg1, neg2;
   logic [31:0] mag1, mag2;
   logic        div_zero, div_ovf, shortcut, accept;
   logic [31:0] special_res;

   always_comb begin
      in_m    = 1'b1;
      in_div  = 1'b0;
      in_rem  = 1'b0;
      in_sgn1 = 1'b0;
      in_sgn2 = 1'b0;
      in_signed_div = 1'b0;
      case (alucode)
         `ALU_MUL:    ;
         `ALU_MULH:   begin in_sgn1 = 1'b1; in_sgn2 = 1'b1; end
         `ALU_MULHSU: in_sgn1 = 1'b1;
         `ALU_MULHU:  ;
         `ALU_DIV:    begin in_div = 1'b1; in_sgn1 = 1'b1; in_sgn2 = 1'b1; in_signed_div = 1'b1; end
         `ALU_DIVU:   in_div = 1'b1;
         `ALU_REM:    begin in_div = 1'b1; in_rem = 1'b1; in_sgn1 = 1'b1; in_sgn2 = 1'b1;
                            in_signed_div = 1'b1; end
         `ALU_REMU:   begin in_div = 1'b1; in_rem = 1'b1; end
         default:     in_m = 1'b0;
      endcase
   end

   assign neg1 = in_sgn1 & op1[31];
   assign neg2 = in_sgn2 & op2[31];
   assign mag1 = neg1 ? (32'd0 - op1) : op1;
   assign mag2 = neg2 ? (32'd0 - op2) : op2;

   assign div_zero = in_div && (op2 == 32'd0);
   assign div_ovf  = in_signed_div && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_a, fast_b, fast_prod;
   assign fast_a    = in_sgn1 ? {{32{op1[31]}}, op1} : {32'd0, op1};
   assign fast_b    = in_sgn2 ? {{32{op2[31]}}, op2} : {32'd0, op2};
   assign fast_prod = fast_a * fast_b;
   assign shortcut  = div_zero || div_ovf || !in_div;
`else
   assign shortcut  = div_zero || div_ovf;
`endif

   always_comb begin
      special_res = 32'd0;
      if (div_zero)
         special_res = in_rem ? op1 : 32'hFFFF_FFFF;
      else if (div_ovf)
         special_res = in_rem ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
      else if (!in_div)
         special_res = (alucode == `ALU_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`endif
   end

   assign accept = (state_q == IDLE) && start && !flush && in_m;

   // One iteration step for both datapaths, computed from the latched accumulators.
   logic        op_div, op_rem;
   logic [32:0] mul_sum;
   logic [31:0] mul_hi_n, mul_lo_n;
   logic [32:0] div_shift;
   logic        div_ok;
   logic [31:0] div_sub, div_hi_n, div_lo_n;
   logic [63:0] prod_s;
   logic [31:0] div_val, final_res;

   assign op_div = (op_q == `ALU_DIV) || (op_q == `ALU_DIVU) ||
                   (op_q == `ALU_REM) || (op_q == `ALU_REMU);
   assign op_rem = (op_q == `ALU_REM) || (op_q == `ALU_REMU);

   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
   assign mul_hi_n = mul_sum[32:1];
   assign mul_lo_n = {mul_sum[0], acc_lo_q[31:1]};

   assign div_shift = {acc_hi_q, acc_lo_q[31]};
   assign div_ok    = div_shift >= {1'b0, mag_b_q};
   assign div_sub   = div_shift[31:0] - mag_b_q;
   assign div_hi_n  = div_ok ? div_sub : div_shift[31:0];
   assign div_lo_n  = {acc_lo_q[30:0], div_ok};

   assign prod_s  = neg_q ? (64'd0 - {mul_hi_n, mul_lo_n}) : {mul_hi_n, mul_lo_n};
   assign div_val = op_rem ? div_hi_n : div_lo_n;

   always_comb begin
      if (op_div)
         final_res = neg_q ? (32'd0 - div_val) : div_val;
      else if (op_q == `ALU_MUL)
         final_res = prod_s[31:0];
      else
         final_res = prod_s[63:32];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = shortcut ? DONE : CALC;
         CALC:    if (flush) state_d = IDLE;
                  else if (cnt_q == 5'd0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE) && !flush;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         op_q     <= 6'd0;
         neg_q    <= 1'b0;
         mag_b_q  <= 32'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         cnt_q    <= 5'd0;
         result   <= 32'd0;
      end else if (accept) begin
         op_q     <= alucode;
         neg_q    <= neg1 ^ (in_rem ? 1'b0 : neg2);
         mag_b_q  <= in_div ? mag2 : mag1;
         acc_hi_q <= 32'd0;
         acc_lo_q <= in_div ? mag1 : mag2;
         cnt_q    <= 5'd31;
         if (shortcut)
            result <= special_res;
      end else if ((state_q == CALC) && !flush) begin
         acc_hi_q <= op_div ? div_hi_n : mul_hi_n;
         acc_lo_q <= op_div ? div_lo_n : mul_lo_n;
         cnt_q    <= cnt_q - 5'd1;
         if (cnt_q == 5'd0)
            result <= final_res;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; latencies are measured from the accepting edge.
`ifndef ALU_MUL
`define ALU_MUL    6'h20
`define ALU_MULH   6'h21
`define ALU_MULHSU 6'h22
`define ALU_MULHU  6'h23
`define ALU_DIV    6'h24
`define ALU_DIVU   6'h25
`define ALU_REM    6'h26
`define ALU_REMU   6'h27
`endif

module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        nrst, start, flush;
   logic [5:0]  alucode;
   logic [31:0] op1, op2, result;
   logic        busy, done;
   int          checks = 0;
   int          errors = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   typedef struct {
      logic [5:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   muldiv_unit dut (
      .clk(clk), .nrst(nrst), .start(start), .alucode(alucode),
      .op1(op1), .op2(op2), .flush(flush),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; alucode = code; op1 = a; op2 = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (!done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0; start = 1'b0; flush = 1'b0; alucode = 6'd0; op1 = 32'd0; op2 = 32'd0;
      #12;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
      end
      #1 nrst = 1'b1;
   endtask

   task automatic run_table(input string name, input vec_t v[], input int exp_lat);
      int lat;
      foreach (v[i]) begin
         issue(v[i].code, v[i].a, v[i].b);
         wait_done(1, lat);
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, exp_lat);
         end
         checks++;
         if (result !== v[i].exp) begin
            errors++;
            $display("FAIL %s[%0d] result: got %h expected %h", name, i, result, v[i].exp);
         end
      end
   endtask

   task automatic test_mul;
      vec_t v[] = '{
         '{`ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
         '{`ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
         '{`ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{`ALU_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF},
         '{`ALU_MULH,   32'h4000_0000,  32'd4,         32'h0000_0001},
         '{`ALU_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000}
      };
      run_table("mul", v, MUL_LAT);
   endtask

   task automatic test_div;
      vec_t v[] = '{
         '{`ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
         '{`ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
         '{`ALU_DIVU, 32'd100,       32'd7,         32'd14},
         '{`ALU_REMU, 32'd100,       32'd7,         32'd2},
         '{`ALU_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
         '{`ALU_REM,  32'd7,         32'hFFFF_FFFE, 32'd1},
         '{`ALU_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF}
      };
      run_table("div", v, 33);
   endtask

   task automatic test_special;
      vec_t v[] = '{
         '{`ALU_DIVU, 32'd55,        32'd0,         32'hFFFF_FFFF},
         '{`ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
         '{`ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
         '{`ALU_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF},
         '{`ALU_REMU, 32'd123,       32'd0,         32'd123},
         '{`ALU_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB}
      };
      run_table("special", v, 1);
   endtask

   task automatic test_back_to_back;
      int lat;
      issue(`ALU_DIVU, 32'd9, 32'd3);
      wait_done(1, lat);
      start = 1'b1; alucode = `ALU_DIVU; op1 = 32'd50; op2 = 32'd5;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_after_done: done=%b busy=%b expected 0 0", done, busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b expected 1", busy);
      end
      wait_done(1, lat);
      checks++;
      if (lat !== 33 || result !== 32'd10) begin
         errors++;
         $display("FAIL b2b_result: lat=%0d result=%h expected 33 0000000a", lat, result);
      end
   endtask

   task automatic test_ignore_non_m;
      int dones = 0;
      @(posedge clk); #1;
      start = 1'b1; alucode = 6'h00; op1 = 32'd1; op2 = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL non_m_busy: busy=%b expected 0", busy);
      end
      for (int i = 0; i < 4; i++) begin
         if (done) dones++;
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 0 || result !== 32'd10) begin
         errors++;
         $display("FAIL non_m_result: dones=%0d result=%h expected 0 0000000a", dones, result);
      end
   endtask

   task automatic test_busy_start;
      int lat;
      issue(`ALU_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
      start = 1'b1; alucode = `ALU_DIV; op1 = 32'd1000; op2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_busy: busy=%b expected 1", busy);
      end
      wait_done(6, lat);
      checks++;
      if (lat !== 33 || result !== 32'd14) begin
         errors++;
         $display("FAIL busy_start_result: lat=%0d result=%h expected 33 0000000e", lat, result);
      end
   endtask

   task automatic test_reset_mid;
      int dones = 0;
      issue(`ALU_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
      nrst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
      end
      #2 nrst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      checks++;
      if (dones !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_nodone: dones=%0d busy=%b expected 0 0", dones, busy);
      end
   endtask

   task automatic test_flush;
      int dones = 0;
      int lat;
      issue(`ALU_DIV, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: busy=%b expected 0", busy);
      end
      for (int i = 0; i < 40; i++) begin
         if (done) dones++;
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 0 || result !== 32'd0) begin
         errors++;
         $display("FAIL flush_nodone: dones=%0d result=%h expected 0 00000000", dones, result);
      end
      start = 1'b1; flush = 1'b1; alucode = `ALU_DIVU; op1 = 32'd8; op2 = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_start_idle: busy=%b expected 0", busy);
      end
      issue(`ALU_DIVU, 32'd100, 32'd7);
      wait_done(1, lat);
      checks++;
      if (lat !== 33 || result !== 32'd14) begin
         errors++;
         $display("FAIL flush_restart: lat=%0d result=%h expected 33 0000000e", lat, result);
      end
   endtask

   initial begin
      test_reset;
      test_mul;
      test_div;
      test_special;
      test_back_to_back;
      test_ignore_non_m;
      test_busy_start;
      test_reset_mid;
      test_flush;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
